exec_unit: RTL

- Execute stage directly downstream of the 4x16 register file.
- Takes the two read operands (data1/data2), the opcode and the destination register index, and computes the result.
- Returns the result to the register file write port as a one-cycle write request.
- Single-cycle ALU ops; multi-cycle iterative multiply; valid/ready handshake toward the decode/issue logic.

---
 rtl/exec_unit_if.sv | 29 ++
 rtl/exec_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_if.sv
// Issue/writeback bundle between decode, exec_unit and the 4x16 register file.
// The master side issues ops; the slave side (exec_unit) returns write requests.
interface exec_unit_if #(
  parameter int W  = 16,
  parameter int RA = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [RA-1:0] dst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          wr_en;
  logic [RA-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          busy;
  logic          flag_z;
  logic          flag_c;

  modport master (
    output in_valid, op, dst, a, b,
    input  in_ready, wr_en, wr_addr, wr_data, busy, flag_z, flag_c
  );

  modport slave (
    input  in_valid, op, dst, a, b,
    output in_ready, wr_en, wr_addr, wr_data, busy, flag_z, flag_c
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus multiply, one-cycle register-file write request.
// Define ITER_MUL_EN for the iterative W-cycle shift-add multiplier; otherwise MUL is combinational.
module exec_unit #(
  parameter int W  = 16,
  parameter int RA = 2
) (
  input  logic         clk,
  input  logic         reset,
  exec_unit_if.slave   bus
);
  localparam int SW = $clog2(W);
  localparam logic [W-1:0] SHIFT_LIM = W'(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd2;
`ifdef ITER_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [1:0] S_MUL  = 2'd1;
`endif

  logic [1:0]    state_q,   state_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic [RA-1:0] wr_addr_q, wr_addr_d;
  logic          flag_z_q,  flag_z_d;
  logic          flag_c_q,  flag_c_d;

  logic [W-1:0]  alu_res;
  logic          alu_c;
  logic [W:0]    alu_wide;

`ifdef ITER_MUL_EN
  logic [2*W-1:0] acc_q,    acc_d;
  logic [2*W-1:0] mcand_q,  mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]  cnt_q,    cnt_d;
  logic [RA-1:0]  dst_q,    dst_d;
  logic [2*W-1:0] acc_nx;
`else
  logic [2*W-1:0] alu_prod;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_wide = '0;
`ifndef ITER_MUL_EN
    alu_prod = '0;
`endif
    case (bus.op)
      OP_ADD: begin
        alu_wide = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res  = alu_wide[W-1:0];
        alu_c    = alu_wide[W];
      end
      OP_SUB: begin
        alu_res = bus.a - bus.b;
        alu_c   = (bus.a < bus.b);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      // The extra bit beside the word catches the last bit shifted out; shift by 0 leaves it clear.
      OP_SHL: if (bus.b < SHIFT_LIM) begin
        alu_wide = {1'b0, bus.a} << bus.b[SW-1:0];
        alu_res  = alu_wide[W-1:0];
        alu_c    = alu_wide[W];
      end
      OP_SHR: if (bus.b < SHIFT_LIM) begin
        alu_wide = {bus.a, 1'b0} >> bus.b[SW-1:0];
        alu_res  = alu_wide[W:1];
        alu_c    = alu_wide[0];
      end
      default: begin
`ifndef ITER_MUL_EN
        alu_prod = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
        alu_res  = alu_prod[W-1:0];
        alu_c    = |alu_prod[2*W-1:W];
`endif
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
`ifdef ITER_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    acc_nx   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
`ifdef ITER_MUL_EN
        if (bus.op == OP_MUL) begin
          state_d  = S_MUL;
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, bus.a};
          mplier_d = bus.b;
          cnt_d    = '0;
          dst_d    = bus.dst;
        end else
`endif
        begin
          state_d   = S_WB;
          wr_data_d = alu_res;
          wr_addr_d = bus.dst;
          flag_z_d  = (alu_res == '0);
          flag_c_d  = alu_c;
        end
      end
`ifdef ITER_MUL_EN
      S_MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SW'(W - 1)) begin
          state_d   = S_WB;
          wr_data_d = acc_nx[W-1:0];
          wr_addr_d = dst_q;
          flag_z_d  = (acc_nx[W-1:0] == '0);
          flag_c_d  = |acc_nx[2*W-1:W];
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: the multiply working registers are reset too, so an aborted op leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
`ifdef ITER_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
`ifdef ITER_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.wr_en    = (state_q == S_WB);
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_c   = flag_c_q;
endmodule
